sdp_ram_clr: RTL and testbench
==============================

Name: sdp_ram_clr

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, one clock.
- Next generation of the team's 8x64 single-port RAM. Adds:
  - parametrised width and depth;
  - per-byte write enables;
  - a read-valid strobe;
  - selectable output register;
  - selectable read-during-write mode;
  - a hardware clear engine that zeroes the array after reset or on request.
- Used as the generic buffer memory under FIFOs and packet stores.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- OUT_REG, 0, 1 adds a second output register stage (read latency 2 instead of 1).
- RDW_MODE, 0, same-address read-during-write: 0 returns old data, 1 returns new (byte-merged) data.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_be  in  DATA_W/8  byte enables; bit i covers data[8i+7:8i].
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data; holds last value when no read completes.
- rd_valid  out  1  one-cycle strobe, rd_data valid this cycle.
- clr_req  in  1  pulse requesting a full array clear.
- busy  out  1  clear engine active; accesses ignored.

Behaviour:
- Reset (rst_n low, async):
  - rd_data=0, rd_valid=0, busy=1, pipeline registers cleared, clear address counter=0.
  - Array contents are not reset by flops; the clear engine zeroes them.
- FSM states: CLEAR and READY.
  - Reset enters CLEAR.
  - CLEAR: each cycle writes all-zero to clr_addr, then clr_addr++. Exactly DEPTH cycles.
  - After writing address DEPTH-1, go to READY. busy deasserts on the first READY cycle.
  - READY plus clr_req=1: go to CLEAR next cycle with clr_addr=0. busy=1 from that next cycle.
  - clr_req in CLEAR is ignored; it does not restart the clear.
  - Reset asserted mid-clear restarts the clear from address 0 after release.
- Write (READY only):
  - wr_en=1 updates the bytes with wr_be[i]=1 at wr_addr on the clock edge.
  - Bytes with wr_be=0 are unchanged. wr_be=0 with wr_en=1 is a no-op.
- Read (READY only):
  - rd_en=1 in cycle N gives rd_data and rd_valid=1 in cycle N+1+OUT_REG.
  - Back-to-back reads are allowed; throughput is 1 per cycle.
  - rd_valid is 0 in every cycle with no completing read.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the pre-write word with enabled bytes replaced by wr_data.
  - Different addresses do not interact.
- While busy:
  - wr_en and rd_en are ignored; no array write, no rd_valid.
  - Reads already in flight when CLEAR starts still complete and return their data.
- Transition into CLEAR via clr_req: a wr_en in the same cycle as clr_req is performed. The clear then overwrites it.
- Address arithmetic is modulo DEPTH; the clear counter wraps only at FSM exit.

Optional Feature:
- Macro: SDP_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte, written alongside data; the clear writes parity 0.
  - Output parity_err (1 bit) is aligned with rd_valid. It is 1 if any byte of the read word fails parity.
  - Input inj_par (1 bit): when 1 during a write, the parity of every enabled byte is stored inverted (error injection).
  - parity_err resets to 0.
- Undefined:
  - No parity storage, no parity_err or inj_par ports.
  - Functionally identical otherwise.

Decomposition:
- Package sdp_ram_pkg:
  - FSM state enum (ST_CLEAR, ST_READY);
  - RDW_OLD/RDW_NEW constants;
  - a function computing per-byte even parity for a DATA_W word.
- One sub-module, sdp_ram_array: a pure storage array with a byte-enabled write port and a synchronous read port, with no reset.
- Top level holds:
  - the clear FSM;
  - write muxing between user and clear engine;
  - RDW bypass logic;
  - the OUT_REG stage;
  - the rd_valid pipeline.

Test Plan:
- Reset release, DEPTH=64, then read all addresses → busy=1 for exactly 64 cycles. Every read returns 0 with rd_valid one cycle after rd_en (OUT_REG=0).
- Write 0xAABBCCDD to addr 5 with be=4'b1111, then write 0x11223344 with be=4'b0101 → read addr 5 returns 0xAA22CC44.
- Same-cycle write 0xFFFFFFFF (be=1111) and read at addr 9 holding 0x12345678 → RDW_MODE=0 returns 0x12345678; RDW_MODE=1 returns 0xFFFFFFFF.
- OUT_REG=1, rd_en on 3 consecutive cycles to addr 1,2,3 → rd_valid high for 3 consecutive cycles starting 2 cycles after the first rd_en, data in order.
- Pulse clr_req after filling data; deassert rst_n at clear cycle 20 and release → busy stays high for 64 full cycles after release. All reads return 0; accesses during busy produce no rd_valid and no writes.
- SDP_RAM_PARITY_EN: write addr 3 with inj_par=1, be=4'b0010, then read → parity_err=1 with rd_valid. Rewrite addr 3 with inj_par=0 and re-read → parity_err=0.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM with clear engine.
// Contents: clear-engine FSM state type, read-during-write mode constants,
// and a per-byte even-parity helper (operates on a zero-extended word of up
// to MAX_DATA_W bits; callers truncate the result to their byte count).
package sdp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } sdp_state_e;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  localparam int unsigned MAX_DATA_W = 1024;
  localparam int unsigned MAX_NB     = MAX_DATA_W / 8;

  // Bit i is the XOR of data[8i+7:8i]; storing it makes each 9-bit lane even.
  function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DATA_W-1:0] d);
    logic [MAX_NB-1:0] p;
    for (int i = 0; i < MAX_NB; i++) begin
      p[i] = ^d[i*8 +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/sdp_ram_array.sv
// Pure storage array: one lane-enabled write port and one registered read
// port on the same clock. No reset; contents are initialised by the clear
// engine in the top level. A same-address read and write on one edge returns
// the pre-write word.
// Ports:
//   clk    clock
//   we     write enable; waddr/wbe/wdata write address, lane enables, data
//   re     read enable; raddr read address
//   rdata  registered read word, holds its value when re is low
module sdp_ram_array #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [LANES-1:0]          wbe,
  input  logic [LANES*LANE_W-1:0]   wdata,
  input  logic                      re,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [LANES*LANE_W-1:0]   rdata
);

  logic [LANES*LANE_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe[i]) begin
          mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sdp_ram_clr.sv
// Simple-dual-port RAM with byte enables, read-valid strobe, optional output
// register, selectable read-during-write behaviour and a clear engine that
// zeroes the array after reset or on clr_req.
// Optional feature: define SDP_RAM_PARITY_EN to store one even-parity bit per
// byte and add the inj_par input and parity_err output.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_be/wr_data   write port (ignored while busy)
//   rd_en/rd_addr        read request (ignored while busy)
//   rd_data/rd_valid     read result, latency 1 + OUT_REG
//   clr_req              request a full array clear
//   busy                 clear engine active
//   inj_par, parity_err  parity error injection / detection (parity build)
module sdp_ram_clr
  import sdp_ram_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned RDW_MODE = RDW_OLD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
`ifdef SDP_RAM_PARITY_EN
  input  logic                inj_par,
  output logic                parity_err,
`endif
  input  logic                clr_req,
  output logic                busy
);

  localparam int unsigned NB = DATA_W / 8;
`ifdef SDP_RAM_PARITY_EN
  localparam int unsigned LANE_W = 9;
`else
  localparam int unsigned LANE_W = 8;
`endif
  localparam int unsigned WORD_W = NB * LANE_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // Clear FSM
  sdp_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST_ADDR) state_d = ST_READY;
      end
      ST_READY: begin
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  logic wr_fire, rd_fire;
  assign wr_fire = !busy && wr_en;
  assign rd_fire = !busy && rd_en;

  // Lane packing: each lane is a data byte, plus its parity bit when enabled.
  logic [WORD_W-1:0] usr_word, rd_word, arr_rdata;
  logic [DATA_W-1:0] rd_bytes;
  logic              s1_err;

`ifdef SDP_RAM_PARITY_EN
  logic [NB-1:0] usr_par, rd_par;
  assign usr_par = NB'(byte_parity(MAX_DATA_W'(wr_data))) ^ {NB{inj_par}};
  assign s1_err  = |(NB'(byte_parity(MAX_DATA_W'(rd_bytes))) ^ rd_par);
`else
  assign s1_err  = 1'b0;
`endif

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign usr_word[i*LANE_W +: 8] = wr_data[i*8 +: 8];
    assign rd_bytes[i*8 +: 8]      = rd_word[i*LANE_W +: 8];
`ifdef SDP_RAM_PARITY_EN
    assign usr_word[i*LANE_W+8]    = usr_par[i];
    assign rd_par[i]               = rd_word[i*LANE_W+8];
`endif
  end

  // Write mux: the clear engine owns the write port while busy.
  logic [ADDR_W-1:0] arr_waddr;
  logic [NB-1:0]     arr_wbe;
  logic [WORD_W-1:0] arr_wdata;
  logic              arr_we;

  assign arr_we    = busy || wr_fire;
  assign arr_waddr = busy ? clr_addr_q : wr_addr;
  assign arr_wbe   = busy ? '1 : wr_be;
  assign arr_wdata = busy ? '0 : usr_word;

  sdp_ram_array #(
    .LANE_W (LANE_W),
    .LANES  (NB),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wbe   (arr_wbe),
    .wdata (arr_wdata),
    .re    (rd_fire),
    .raddr (rd_addr),
    .rdata (arr_rdata)
  );

  // Bypass capture: remembers a same-address write so the new-data mode can
  // merge it over the (old) array output. Updated only on reads so the merged
  // word holds between reads.
  logic              byp_q, valid1_q;
  logic [NB-1:0]     byp_be_q;
  logic [WORD_W-1:0] byp_word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q      <= 1'b0;
      byp_be_q   <= '0;
      byp_word_q <= '0;
      valid1_q   <= 1'b0;
    end else begin
      valid1_q <= rd_fire;
      if (rd_fire) begin
        byp_q      <= wr_fire && (wr_addr == rd_addr);
        byp_be_q   <= wr_be;
        byp_word_q <= usr_word;
      end
    end
  end

  always_comb begin
    rd_word = arr_rdata;
    if (RDW_MODE == RDW_NEW && byp_q) begin
      for (int i = 0; i < NB; i++) begin
        if (byp_be_q[i]) rd_word[i*LANE_W +: LANE_W] = byp_word_q[i*LANE_W +: LANE_W];
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] out_q;
    logic              valid2_q;
    logic              err2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q    <= '0;
        valid2_q <= 1'b0;
        err2_q   <= 1'b0;
      end else begin
        valid2_q <= valid1_q;
        err2_q   <= valid1_q && s1_err;
        if (valid1_q) out_q <= rd_bytes;
      end
    end

    assign rd_data  = out_q;
    assign rd_valid = valid2_q;
`ifdef SDP_RAM_PARITY_EN
    assign parity_err = err2_q;
`endif
  end else begin : g_noreg
    // The array register has no reset, so mask its output until the first
    // read after reset has completed.
    logic seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seen_q <= 1'b0;
      else        seen_q <= seen_q || valid1_q;
    end

    assign rd_data  = (seen_q || valid1_q) ? rd_bytes : '0;
    assign rd_valid = valid1_q;
`ifdef SDP_RAM_PARITY_EN
    assign parity_err = valid1_q && s1_err;
`endif
  end

endmodule

// File: tb/tb_sdp_ram_clr.sv
module tb_sdp_ram_clr;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0, inj = 1'b0;
  logic [5:0]  wr_addr = '0, rd_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, busy0, busy1, perr0, perr1;

  always #5 clk = ~clk;

  // u_old: OUT_REG=0, old-data RDW; u_new: OUT_REG=1, new-data RDW.
  sdp_ram_clr #(.DATA_W(32), .ADDR_W(6), .OUT_REG(0), .RDW_MODE(0)) u_old (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0),
`ifdef SDP_RAM_PARITY_EN
    .inj_par(inj), .parity_err(perr0),
`endif
    .clr_req(clr_req), .busy(busy0)
  );

  sdp_ram_clr #(.DATA_W(32), .ADDR_W(6), .OUT_REG(1), .RDW_MODE(1)) u_new (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1),
`ifdef SDP_RAM_PARITY_EN
    .inj_par(inj), .parity_err(perr1),
`endif
    .clr_req(clr_req), .busy(busy1)
  );

`ifndef SDP_RAM_PARITY_EN
  assign perr0 = 1'b0;
  assign perr1 = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        pe;
  } exp_t;

  typedef struct {
    logic        we;
    logic [5:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        re;
    logic [5:0]  ra;
    logic [31:0] eo;
    logic [31:0] en;
  } vec_t;

  exp_t        q0[$], q1[$];
  int          checks = 0, errors = 0, edge_n = 0;
  logic [31:0] mem_m [DEPTH];
  logic [3:0]  par_m [DEPTH];
  logic        m_busy = 1'b1;
  int          m_clr = 0;
  logic        use_tbl = 1'b0;
  logic [31:0] tbl_old = '0, tbl_new = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  function automatic logic [31:0] merge32(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [3:0] merge4(logic [3:0] o, logic [3:0] n, logic [3:0] be);
    return (o & ~be) | (n & be);
  endfunction

  function automatic logic [3:0] bpar(logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[i*8 +: 8];
    return p;
  endfunction

  // Behavioural reference applied for the edge about to happen.
  task automatic model_edge();
    exp_t        e0, e1;
    logic [31:0] od, nd;
    logic [3:0]  op, np, wp;
    if (!m_busy) begin
      wp = bpar(wr_data) ^ {4{inj}};
      if (rd_en) begin
        od = mem_m[rd_addr];
        op = par_m[rd_addr];
        nd = od;
        np = op;
        if (wr_en && wr_addr == rd_addr) begin
          nd = merge32(od, wr_data, wr_be);
          np = merge4(op, wp, wr_be);
        end
        e0 = '{edge_n, od, |(bpar(od) ^ op)};
        e1 = '{edge_n + 1, nd, |(bpar(nd) ^ np)};
        if (use_tbl) begin
          e0.d = tbl_old;
          e1.d = tbl_new;
        end
        q0.push_back(e0);
        q1.push_back(e1);
      end
      if (wr_en) begin
        mem_m[wr_addr] = merge32(mem_m[wr_addr], wr_data, wr_be);
        par_m[wr_addr] = merge4(par_m[wr_addr], wp, wr_be);
      end
      if (clr_req) begin
        m_busy = 1'b1;
        m_clr  = 0;
      end
    end else begin
      mem_m[m_clr] = '0;
      par_m[m_clr] = '0;
      if (m_clr == DEPTH - 1) m_busy = 1'b0;
      m_clr++;
    end
  endtask

  task automatic mon(input string nm, input bit have, input exp_t e, input logic v,
                     input logic [31:0] d, input logic pe, output bit pop);
    pop = 1'b0;
    if (have && e.due == edge_n) begin
      pop = 1'b1;
      check({nm, " rd_valid"}, {31'b0, v}, 32'd1);
      check({nm, " rd_data"}, d, e.d);
`ifdef SDP_RAM_PARITY_EN
      check({nm, " parity_err"}, {31'b0, pe}, {31'b0, e.pe});
`endif
    end else begin
      check({nm, " rd_valid idle"}, {31'b0, v}, 32'd0);
    end
  endtask

  task automatic cyc();
    exp_t dummy = '{-1, '0, 1'b0};
    bit   p0, p1;
    model_edge();
    @(posedge clk);
    #1;
    mon("old", q0.size() > 0, (q0.size() > 0) ? q0[0] : dummy, rd_valid0, rd_data0, perr0, p0);
    mon("new", q1.size() > 0, (q1.size() > 0) ? q1[0] : dummy, rd_valid1, rd_data1, perr1, p1);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    check("busy old", {31'b0, busy0}, {31'b0, m_busy});
    check("busy new", {31'b0, busy1}, {31'b0, m_busy});
    edge_n++;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0; inj = 1'b0; wr_be = '0;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    repeat (n) cyc();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    m_busy = 1'b1;
    m_clr  = 0;
    check("reset rd_valid old", {31'b0, rd_valid0}, 32'd0);
    check("reset rd_valid new", {31'b0, rd_valid1}, 32'd0);
    check("reset rd_data old", rd_data0, 32'd0);
    check("reset rd_data new", rd_data1, 32'd0);
    check("reset busy", {30'b0, busy1, busy0}, 32'd3);
    repeat (hold) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Runs while busy with random accesses (all must be ignored); returns cycles.
  task automatic busy_run(output int cnt);
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 200) begin
      cnt++;
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 6'($urandom_range(0, 63));
      wr_be   = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = 6'($urandom_range(0, 63));
      clr_req = 1'($urandom_range(0, 1));
      cyc();
    end
    idle_inputs();
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en   = 1'b1;
      rd_addr = 6'(a);
      cyc();
    end
    idle(3);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    idle_inputs();
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    cyc();
    idle_inputs();
  endtask

  vec_t tbl[12];
  int   n;

  initial begin
    tbl[0]  = '{1'b1, 6'd5,  4'hF, 32'hAABBCCDD, 1'b0, 6'd0,  32'h0,        32'h0};
    tbl[1]  = '{1'b1, 6'd5,  4'h5, 32'h11223344, 1'b0, 6'd0,  32'h0,        32'h0};
    tbl[2]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd5,  32'hAA22CC44, 32'hAA22CC44};
    tbl[3]  = '{1'b1, 6'd9,  4'hF, 32'h12345678, 1'b0, 6'd0,  32'h0,        32'h0};
    tbl[4]  = '{1'b1, 6'd9,  4'hF, 32'hFFFFFFFF, 1'b1, 6'd9,  32'h12345678, 32'hFFFFFFFF};
    tbl[5]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd9,  32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[6]  = '{1'b1, 6'd7,  4'hA, 32'hDEADBEEF, 1'b1, 6'd7,  32'h00000000, 32'hDE00BE00};
    tbl[7]  = '{1'b1, 6'd7,  4'h0, 32'h55555555, 1'b1, 6'd7,  32'hDE00BE00, 32'hDE00BE00};
    tbl[8]  = '{1'b1, 6'd8,  4'hF, 32'hCAFEF00D, 1'b1, 6'd9,  32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[9]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd8,  32'hCAFEF00D, 32'hCAFEF00D};
    tbl[10] = '{1'b1, 6'd63, 4'hF, 32'h01020304, 1'b1, 6'd0,  32'h0,        32'h0};
    tbl[11] = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd63, 32'h01020304, 32'h01020304};

    // Power-on clear: busy for exactly DEPTH cycles, then everything reads 0.
    do_reset(3);
    busy_run(n);
    check("power-on busy cycles", 32'(n), 32'd64);
    read_all();

    // Byte enables, read-during-write, address boundaries.
    for (int i = 0; i < 12; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_be = tbl[i].be; wr_data = tbl[i].wd;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra;
      use_tbl = 1'b1; tbl_old = tbl[i].eo; tbl_new = tbl[i].en;
      cyc();
    end
    use_tbl = 1'b0;
    idle(4);
    check("rd_data hold old", rd_data0, 32'h01020304);
    check("rd_data hold new", rd_data1, 32'h01020304);

    // Back-to-back reads of 1,2,3.
    wr(6'd1, 32'h0000_1111, 4'hF);
    wr(6'd2, 32'h0000_2222, 4'hF);
    wr(6'd3, 32'h0000_3333, 4'hF);
    for (int a = 1; a <= 3; a++) begin
      rd_en = 1'b1; rd_addr = 6'(a);
      cyc();
    end
    idle(3);

    // clr_req with a same-cycle write and an in-flight read; full clear.
    for (int a = 10; a < 20; a++) wr(6'(a), $urandom, 4'hF);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 6'd40; wr_data = 32'h0BAD_F00D; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 6'd12;
    cyc();
    idle_inputs();
    busy_run(n);
    check("clr_req busy cycles", 32'(n), 32'd64);
    read_all();

    // Refill, clear, and reset at clear cycle 20: clear restarts from zero.
    for (int a = 20; a < 30; a++) wr(6'(a), $urandom | 32'h1, 4'hF);
    clr_req = 1'b1;
    cyc();
    idle_inputs();
    repeat (19) cyc();
    do_reset(2);
    busy_run(n);
    check("busy cycles after mid-clear reset", 32'(n), 32'd64);
    read_all();

`ifdef SDP_RAM_PARITY_EN
    inj = 1'b1;
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'h1234_5678; wr_be = 4'b0010;
    cyc();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 6'd3;
    cyc();
    idle(3);
    wr(6'd3, 32'h1234_5678, 4'b0010);
    rd_en = 1'b1; rd_addr = 6'd3;
    cyc();
    idle(3);
`endif

    check("scoreboard old drained", 32'(q0.size()), 32'd0);
    check("scoreboard new drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
